// File: rtl/pe_operand_sequencer_pkg.sv
// pe_operand_sequencer_pkg
// Shared definitions for the PE operand sequencer: datapath widths that
// match the PE register file, and the sequencer FSM state encoding.
package pe_operand_sequencer_pkg;

  localparam int unsigned PE_DATA_W    = 16;
  localparam int unsigned PE_RF_ADDR_W = 4;
  localparam int unsigned PE_LEN_W     = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } seq_state_e;

endpackage

// File: rtl/pe_operand_sequencer_if.sv
// pe_operand_sequencer_if
// Bundles the sequencer's three buses:
//   cmd_*            command from the PE control FSM (valid/ready)
//   raddr_*/rdata_*  two combinational register file read ports
//   op_*             operand pair stream to the MAC (valid/ready, last)
//   busy/done        command status
// modport master : the sequencer itself
// modport slave  : its surroundings (control FSM, register file, MAC)
interface pe_operand_sequencer_if
  import pe_operand_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W = PE_DATA_W,
  parameter int unsigned ADDR_W = PE_RF_ADDR_W,
  parameter int unsigned LEN_W  = PE_LEN_W
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_base_a;
  logic [ADDR_W-1:0] cmd_base_b;
  logic [LEN_W-1:0]  cmd_len;

  logic [ADDR_W-1:0] raddr_a;
  logic [ADDR_W-1:0] raddr_b;
  logic [DATA_W-1:0] rdata_a;
  logic [DATA_W-1:0] rdata_b;

  logic              op_valid;
  logic              op_ready;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              op_last;

  logic              busy;
  logic              done;

  modport master (
    input  cmd_valid, cmd_base_a, cmd_base_b, cmd_len,
    output cmd_ready,
    output raddr_a, raddr_b,
    input  rdata_a, rdata_b,
    output op_valid, op_a, op_b, op_last,
    input  op_ready,
    output busy, done
  );

  modport slave (
    output cmd_valid, cmd_base_a, cmd_base_b, cmd_len,
    input  cmd_ready,
    input  raddr_a, raddr_b,
    output rdata_a, rdata_b,
    input  op_valid, op_a, op_b, op_last,
    output op_ready,
    input  busy, done
  );

endinterface

// File: rtl/pe_operand_sequencer.sv
// pe_operand_sequencer
// Read-side companion to the PE register file. Takes a command (two base
// addresses and a pair count), walks both read ports over consecutive
// addresses (wrapping modulo 2^ADDR_W), registers each operand pair and
// streams it to the MAC with a valid/ready handshake, flagging the last pair.
// Ports:
//   clk  clock
//   rst  synchronous active-high reset (aborts any command in flight)
//   bus  pe_operand_sequencer_if.master (cmd_*, raddr/rdata, op_*, busy, done)
module pe_operand_sequencer
  import pe_operand_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W = PE_DATA_W,
  parameter int unsigned ADDR_W = PE_RF_ADDR_W,
  parameter int unsigned LEN_W  = PE_LEN_W
) (
  input  logic                    clk,
  input  logic                    rst,
  pe_operand_sequencer_if.master  bus
);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ptr_a_q, ptr_b_q;
  logic [LEN_W-1:0]  remaining_q;
  logic              op_valid_q, op_last_q, done_q;
  logic [DATA_W-1:0] op_a_q, op_b_q;

  logic cmd_take;   // command accepted this cycle
  logic ld;         // capture a new pair from the read ports
  logic drain_hs;   // final pair accepted by the MAC
  logic done_d;
  logic last_left;  // the pair being loaded is the final one

  assign last_left = (remaining_q == LEN_W'(1));

  assign bus.raddr_a   = ptr_a_q;
  assign bus.raddr_b   = ptr_b_q;
  assign bus.op_valid  = op_valid_q;
  assign bus.op_a      = op_a_q;
  assign bus.op_b      = op_b_q;
  assign bus.op_last   = op_last_q;
  assign bus.done      = done_q;
  assign bus.busy      = (state_q != ST_IDLE);
  // Held low while rst is asserted so no command is taken during reset.
  assign bus.cmd_ready = (state_q == ST_IDLE) && !rst;

  always_comb begin
    state_d  = state_q;
    cmd_take = 1'b0;
    ld       = 1'b0;
    drain_hs = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid && bus.cmd_ready) begin
          cmd_take = 1'b1;
          state_d  = (bus.cmd_len == '0) ? ST_FIN : ST_RUN;
        end
      end
      ST_RUN: begin
        // The output slot is free when empty or being consumed this cycle.
        ld = !op_valid_q || bus.op_ready;
        if (ld && last_left) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (op_valid_q && bus.op_ready) begin
          drain_hs = 1'b1;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      ST_FIN: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_a_q     <= '0;
      ptr_b_q     <= '0;
      remaining_q <= '0;
      op_valid_q  <= 1'b0;
      op_last_q   <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
    end else begin
      if (cmd_take) begin
        ptr_a_q     <= bus.cmd_base_a;
        ptr_b_q     <= bus.cmd_base_b;
        remaining_q <= bus.cmd_len;
      end
      // rdata is sampled at the same edge as a register file write, so the
      // pre-write contents are captured.
      if (ld) begin
        op_a_q      <= bus.rdata_a;
        op_b_q      <= bus.rdata_b;
        op_valid_q  <= 1'b1;
        op_last_q   <= last_left;
        ptr_a_q     <= ptr_a_q + ADDR_W'(1);
        ptr_b_q     <= ptr_b_q + ADDR_W'(1);
        remaining_q <= remaining_q - LEN_W'(1);
      end
      if (drain_hs) begin
        op_valid_q <= 1'b0;
        op_last_q  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pe_operand_sequencer.sv
// tb_pe_operand_sequencer
// Directed bench for pe_operand_sequencer with a behavioural register file
// (mem[i] = 0x1000+i after init, one synchronous write port).
module tb_pe_operand_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pe_operand_sequencer_if #(.DATA_W(16), .ADDR_W(4), .LEN_W(5)) bus ();

  pe_operand_sequencer #(.DATA_W(16), .ADDR_W(4), .LEN_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Register file model: combinational reads, write commits at posedge.
  logic [15:0] mem [16];
  logic        rf_init = 1'b1;
  logic        we      = 1'b0;
  logic [3:0]  waddr   = '0;
  logic [15:0] wdata   = '0;

  always @(posedge clk) begin
    if (rf_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= 16'h1000 + 16'(i);
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign bus.rdata_a = mem[bus.raddr_a];
  assign bus.rdata_b = mem[bus.raddr_b];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        last;
  } pair_t;

  typedef struct {
    logic [3:0] ba;
    logic [3:0] bb;
    logic [4:0] len;
    logic       stall;  // drive op_ready with the 1,0,0,1,0,1 pattern
    int         first;  // index of first expected pair in exp_tab
    logic       wr;     // write 0xBEEF to ba in the first read cycle
  } cmd_t;

  pair_t exp_tab[15];
  cmd_t  cmd_tab[6];

  // Issues a command; returns at the negedge of the first cycle after the
  // handshake cycle.
  task automatic issue(input logic [3:0] ba, input logic [3:0] bb, input logic [4:0] len);
    @(negedge clk);
    chk("cmd_ready before issue", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid  = 1'b1;
    bus.cmd_base_a = ba;
    bus.cmd_base_b = bb;
    bus.cmd_len    = len;
    @(negedge clk);
    bus.cmd_valid  = 1'b0;
    bus.cmd_base_a = 4'hF;
    bus.cmd_base_b = 4'hF;
    bus.cmd_len    = 5'd7;
  endtask

  task automatic run_cmd(input cmd_t cm);
    int          n;
    int          c;
    int          last_c;
    bit          first_seen;
    logic        pv, pr, pl, rdy;
    logic [15:0] pa, pb;
    logic [5:0]  pat;
    n = 0; c = 1; last_c = 0; first_seen = 0;
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pa = '0; pb = '0;
    pat = 6'b101001;
    issue(cm.ba, cm.bb, cm.len);
    chk("busy after accept", 32'(bus.busy), 32'd1);
    chk("raddr_a at start", 32'(bus.raddr_a), 32'(cm.ba));
    chk("raddr_b at start", 32'(bus.raddr_b), 32'(cm.bb));
    while (n < int'(cm.len) && c < 200) begin
      we = 1'b0;
      if (cm.wr && c == 1) begin
        we = 1'b1; waddr = cm.ba; wdata = 16'hBEEF;
      end
      chk("no early done", 32'(bus.done), 32'd0);
      if (pv && !pr) begin
        chk("stall holds valid", 32'(bus.op_valid), 32'd1);
        chk("stall holds a", 32'(bus.op_a), 32'(pa));
        chk("stall holds b", 32'(bus.op_b), 32'(pb));
        chk("stall holds last", 32'(bus.op_last), 32'(pl));
      end
      if (!first_seen && bus.op_valid) begin
        first_seen = 1;
        chk("first valid latency", 32'(c), 32'd2);
      end
      rdy = cm.stall ? pat[c % 6] : 1'b1;
      bus.op_ready = rdy;
      if (bus.op_valid && rdy) begin
        chk("pair a", 32'(bus.op_a), 32'(exp_tab[cm.first + n].a));
        chk("pair b", 32'(bus.op_b), 32'(exp_tab[cm.first + n].b));
        chk("pair last", 32'(bus.op_last), 32'(exp_tab[cm.first + n].last));
        n++;
        last_c = c;
      end
      pv = bus.op_valid; pr = rdy; pa = bus.op_a; pb = bus.op_b; pl = bus.op_last;
      @(negedge clk);
      c++;
    end
    we = 1'b0;
    chk("pair count", 32'(n), 32'(cm.len));
    if (!cm.stall) chk("back-to-back pairs", 32'(last_c), 32'(cm.len) + 32'd1);
    chk("done after last", 32'(bus.done), 32'd1);
    chk("valid cleared", 32'(bus.op_valid), 32'd0);
    chk("last cleared", 32'(bus.op_last), 32'd0);
    chk("cmd_ready back", 32'(bus.cmd_ready), 32'd1);
    chk("busy cleared", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("done one cycle", 32'(bus.done), 32'd0);
    chk("no extra valid", 32'(bus.op_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_tab[0]  = '{16'h1002, 16'h1008, 1'b0};
    exp_tab[1]  = '{16'h1003, 16'h1009, 1'b0};
    exp_tab[2]  = '{16'h1004, 16'h100A, 1'b0};
    exp_tab[3]  = '{16'h1005, 16'h100B, 1'b1};
    exp_tab[4]  = '{16'h100E, 16'h100F, 1'b0};
    exp_tab[5]  = '{16'h100F, 16'h1000, 1'b0};
    exp_tab[6]  = '{16'h1000, 16'h1001, 1'b1};
    exp_tab[7]  = '{16'h1005, 16'h100A, 1'b0};
    exp_tab[8]  = '{16'h1006, 16'h100B, 1'b0};
    exp_tab[9]  = '{16'h1007, 16'h100C, 1'b0};
    exp_tab[10] = '{16'h1008, 16'h100D, 1'b0};
    exp_tab[11] = '{16'h1009, 16'h100E, 1'b1};
    exp_tab[12] = '{16'h1000, 16'h1005, 1'b1};
    exp_tab[13] = '{16'h1003, 16'h1000, 1'b1};
    exp_tab[14] = '{16'hBEEF, 16'h1000, 1'b1};

    cmd_tab[0] = '{4'd2,  4'd8,  5'd4, 1'b0, 0,  1'b0};
    cmd_tab[1] = '{4'd14, 4'd15, 5'd3, 1'b0, 4,  1'b0};
    cmd_tab[2] = '{4'd5,  4'd10, 5'd5, 1'b1, 7,  1'b0};
    cmd_tab[3] = '{4'd0,  4'd5,  5'd1, 1'b0, 12, 1'b0};
    cmd_tab[4] = '{4'd3,  4'd0,  5'd1, 1'b0, 13, 1'b1};
    cmd_tab[5] = '{4'd3,  4'd0,  5'd1, 1'b0, 14, 1'b0};

    bus.cmd_valid  = 1'b0;
    bus.cmd_base_a = '0;
    bus.cmd_base_b = '0;
    bus.cmd_len    = '0;
    bus.op_ready   = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("cmd_ready in reset", 32'(bus.cmd_ready), 32'd0);
    chk("op_valid in reset", 32'(bus.op_valid), 32'd0);
    rf_init = 1'b0;
    rst     = 1'b0;
    @(negedge clk);
    chk("cmd_ready after reset", 32'(bus.cmd_ready), 32'd1);
    chk("busy after reset", 32'(bus.busy), 32'd0);
    chk("done after reset", 32'(bus.done), 32'd0);
    chk("op_valid after reset", 32'(bus.op_valid), 32'd0);
    chk("op_last after reset", 32'(bus.op_last), 32'd0);
    chk("op_a after reset", 32'(bus.op_a), 32'd0);
    chk("op_b after reset", 32'(bus.op_b), 32'd0);
    chk("raddr_a after reset", 32'(bus.raddr_a), 32'd0);
    chk("raddr_b after reset", 32'(bus.raddr_b), 32'd0);

    // Streaming, pointer wrap, backpressure
    for (int k = 0; k < 3; k++) run_cmd(cmd_tab[k]);

    // Zero-length command: FIN then done, no operand
    bus.op_ready = 1'b1;
    issue(4'd1, 4'd1, 5'd0);
    chk("len0 busy", 32'(bus.busy), 32'd1);
    chk("len0 no valid", 32'(bus.op_valid), 32'd0);
    chk("len0 done not yet", 32'(bus.done), 32'd0);
    @(negedge clk);
    chk("len0 done pulse", 32'(bus.done), 32'd1);
    chk("len0 still no valid", 32'(bus.op_valid), 32'd0);
    chk("len0 cmd_ready", 32'(bus.cmd_ready), 32'd1);
    @(negedge clk);
    chk("len0 done ends", 32'(bus.done), 32'd0);

    // Reset in the middle of a 6-pair command
    issue(4'd0, 4'd4, 5'd6);
    @(negedge clk);
    chk("abort pair0 valid", 32'(bus.op_valid), 32'd1);
    chk("abort pair0 a", 32'(bus.op_a), 32'h1000);
    @(negedge clk);
    chk("abort pair1 a", 32'(bus.op_a), 32'h1001);
    chk("abort pair1 b", 32'(bus.op_b), 32'h1005);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort valid cleared", 32'(bus.op_valid), 32'd0);
    chk("abort busy cleared", 32'(bus.busy), 32'd0);
    chk("abort no done", 32'(bus.done), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort stays quiet done", 32'(bus.done), 32'd0);
      chk("abort stays quiet valid", 32'(bus.op_valid), 32'd0);
    end

    // Post-abort single pair, then read/write coherency on address 3
    for (int k = 3; k < 6; k++) run_cmd(cmd_tab[k]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
